md_unit: RTL and testbench

- Multiply/divide unit for the EX stage, fed by the operands the decode stage forwards into the ID/EX register.
- Executes mult, multu, div and divu over multiple cycles, and holds the architectural HI/LO registers.
- Exports busy so the hazard unit can stall md-class instructions in decode.
- Serves mthi/mtlo writes and mfhi/mflo reads.

---
 rtl/md_unit_if.sv | 22 ++
 rtl/md_unit.sv | 144 ++++++++++++++
 tb/tb_md_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Handshake and result bus between the EX-stage issue logic and the multiply/divide unit.
// The master drives requests and operands; the slave returns busy and the HI/LO registers.
interface md_unit_if;
    logic        start;
    logic [1:0]  md_op;
    logic [1:0]  hilo_we;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, hilo_we, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, md_op, hilo_we, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at issue into shadow registers and committed atomically when the busy window ends.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Returns {commit_valid, hi, lo}; commit_valid is low only for a divide by zero.
    function automatic logic [64:0] md_compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        logic [31:0] abs_a;
        logic [31:0] abs_b;
        logic [31:0] div_b;
        logic [31:0] q;
        logic [31:0] r;
        logic [64:0] res;
        prod  = 64'd0;
        abs_a = 32'd0;
        abs_b = 32'd0;
        div_b = 32'd1;
        q     = 32'd0;
        r     = 32'd0;
        res   = 65'd0;
        case (op)
            2'd0: begin
                prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res  = {1'b1, prod};
            end
            2'd1: begin
                prod = {32'd0, a} * {32'd0, b};
                res  = {1'b1, prod};
            end
            2'd2: begin
                // Divide magnitudes so 0x80000000 / -1 needs no special case.
                abs_a = a[31] ? (32'd0 - a) : a;
                abs_b = b[31] ? (32'd0 - b) : b;
                div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
                q     = abs_a / div_b;
                r     = abs_a % div_b;
                q     = (a[31] ^ b[31]) ? (32'd0 - q) : q;
                r     = a[31] ? (32'd0 - r) : r;
                res   = {(b != 32'd0), r, q};
            end
            2'd3: begin
                div_b = (b == 32'd0) ? 32'd1 : b;
                res   = {(b != 32'd0), a % div_b, a / div_b};
            end
            default: begin
                res = 65'd0;
            end
        endcase
        return res;
    endfunction

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [31:0]      hi_q,        hi_d;
    logic [31:0]      lo_q,        lo_d;
    logic [31:0]      shadow_hi_q, shadow_hi_d;
    logic [31:0]      shadow_lo_q, shadow_lo_d;
    logic             commit_q,    commit_d;
    logic             busy_q,      busy_d;
    logic [64:0]      md_res_s;

    assign md_res_s = md_compute(bus.md_op, bus.A, bus.B);

    // Next-state, counter, shadow capture and HI/LO update logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        commit_d    = commit_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shadow_hi_d = md_res_s[63:32];
                    shadow_lo_d = md_res_s[31:0];
                    commit_d    = md_res_s[64];
                    cnt_d       = bus.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d     = S_BUSY;
                end else begin
                    hi_d = bus.hilo_we[1] ? bus.A : hi_q;
                    lo_d = bus.hilo_we[0] ? bus.A : lo_q;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    hi_d    = commit_q ? shadow_hi_q : hi_q;
                    lo_d    = commit_q ? shadow_lo_q : lo_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        busy_d = (state_d == S_BUSY);
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            shadow_hi_q <= 32'd0;
            shadow_lo_q <= 32'd0;
            commit_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            commit_q    <= commit_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic reference model.
module tb_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    md_unit_if bus();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; divide by zero leaves HI/LO as they were.
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] eh, output logic [31:0] el);
        longint      sp, sa, sb, q, r;
        logic [63:0] up;
        eh = model_hi;
        el = model_lo;
        case (op)
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                eh = sp[63:32];
                el = sp[31:0];
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            2'd2: begin
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            default: begin
                if (b != 32'd0) begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    // Issues one operation and reports busy length, HI/LO stability during busy and the final HI/LO.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [1:0] we,
                         output int nbusy, output bit held_ok, output logic [31:0] hi_o, output logic [31:0] lo_o);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        hi0 = bus.HI;
        lo0 = bus.LO;
        bus.start   = 1'b1;
        bus.md_op   = op;
        bus.A       = a;
        bus.B       = b;
        bus.hilo_we = we;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.hilo_we = 2'b00;
        bus.A       = $urandom;
        bus.B       = $urandom;
        nbusy   = 0;
        held_ok = 1'b1;
        while (bus.busy === 1'b1 && nbusy < 64) begin
            nbusy++;
            if (bus.HI !== hi0 || bus.LO !== lo0) held_ok = 1'b0;
            @(negedge clk);
        end
        hi_o = bus.HI;
        lo_o = bus.LO;
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] we, input logic [31:0] eh, input logic [31:0] el);
        int          nb;
        bit          held;
        logic [31:0] h, l;
        int          exp_nb;
        exp_nb = op[1] ? DIV_N : MULT_N;
        do_op(op, a, b, we, nb, held, h, l);
        total++;
        if (nb !== exp_nb) begin bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, nb, exp_nb); end
        total++;
        if (held !== 1'b1) begin bad++; $display("FAIL %s hilo_held: got %0d want 1", name, held); end
        total++;
        if (h !== eh) begin bad++; $display("FAIL %s HI: got %h want %h", name, h, eh); end
        total++;
        if (l !== el) begin bad++; $display("FAIL %s LO: got %h want %h", name, l, el); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s busy_after: got %b want 0", name, bus.busy); end
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic do_hilo(input logic [1:0] we, input logic [31:0] a);
        @(negedge clk);
        bus.hilo_we = we;
        bus.A       = a;
        @(negedge clk);
        bus.hilo_we = 2'b00;
        bus.A       = $urandom;
        if (we[1]) model_hi = a;
        if (we[0]) model_lo = a;
    endtask

    task automatic check_hilo(input string name);
        total++;
        if (bus.HI !== model_hi) begin bad++; $display("FAIL %s HI: got %h want %h", name, bus.HI, model_hi); end
        total++;
        if (bus.LO !== model_lo) begin bad++; $display("FAIL %s LO: got %h want %h", name, bus.LO, model_lo); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        total++;
        if (bus.HI !== 32'd0) begin bad++; $display("FAIL reset HI: got %h want 0", bus.HI); end
        total++;
        if (bus.LO !== 32'd0) begin bad++; $display("FAIL reset LO: got %h want 0", bus.LO); end
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
    endtask

    task automatic test_plan_arith();
        check_op("mult_neg",  2'd0, 32'hFFFFFFFD, 32'd5, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFF1);
        check_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'd2, 2'b00, 32'h00000001, 32'hFFFFFFFE);
        check_op("div_neg",   2'd2, 32'hFFFFFFF9, 32'd2, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_op("divu_7_2",  2'd3, 32'd7,        32'd2, 2'b00, 32'd1,        32'd3);
        check_op("div_ovf",   2'd2, 32'h80000000, 32'hFFFFFFFF, 2'b00, 32'h00000000, 32'h80000000);
    endtask

    task automatic test_hilo_write();
        do_hilo(2'b10, 32'h11);
        check_hilo("mthi");
        do_hilo(2'b01, 32'h22);
        check_hilo("mtlo");
        do_hilo(2'b11, 32'hCAFE0001);
        check_hilo("mt_both");
        do_hilo(2'b10, 32'h11);
        do_hilo(2'b01, 32'h22);
        check_hilo("preset");
    endtask

    task automatic test_div_zero();
        check_op("divu_zero", 2'd3, 32'h1234, 32'd0, 2'b00, 32'h11, 32'h22);
        check_op("div_zero",  2'd2, 32'h8000, 32'd0, 2'b00, 32'h11, 32'h22);
    endtask

    task automatic test_start_with_hilo();
        check_op("start_wins", 2'd0, 32'd3, 32'd4, 2'b11, 32'd0, 32'h0000000C);
    endtask

    task automatic test_start_while_busy();
        int nb;
        bit held;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 2'd0; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        nb = 0;
        held = 1'b1;
        while (bus.busy === 1'b1 && nb < 64) begin
            nb++;
            if (bus.HI !== model_hi || bus.LO !== model_lo) held = 1'b0;
            if (nb == 2) begin
                bus.start = 1'b1; bus.md_op = 2'd2; bus.hilo_we = 2'b11; bus.A = 32'hDEAD; bus.B = 32'd1;
            end else begin
                bus.start = 1'b0; bus.hilo_we = 2'b00;
            end
            @(negedge clk);
        end
        bus.start = 1'b0; bus.hilo_we = 2'b00;
        total++;
        if (nb !== MULT_N) begin bad++; $display("FAIL busy_ignore busy_cycles: got %0d want %0d", nb, MULT_N); end
        total++;
        if (held !== 1'b1) begin bad++; $display("FAIL busy_ignore hilo_held: got %0d want 1", held); end
        model_hi = 32'd0;
        model_lo = 32'h0000000C;
        check_hilo("busy_ignore");
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_ignore no_restart: got %b want 0", bus.busy); end
        check_hilo("busy_ignore_after");
    endtask

    task automatic test_reset_abort();
        int nb;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 2'd2; bus.A = 32'd100; bus.B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        nb = 0;
        while (nb < 3) begin
            total++;
            if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort busy_cycle%0d: got %b want 1", nb + 1, bus.busy); end
            nb++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b want 0", bus.busy); end
        model_hi = 32'd0;
        model_lo = 32'd0;
        check_hilo("abort");
        do_hilo(2'b01, 32'h5);
        check_hilo("abort_mtlo");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                do_hilo(2'($urandom_range(1, 3)), a);
                check_hilo("rand_hilo");
            end else begin
                op = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) b = 32'd0;
                else if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
                model_op(op, a, b, eh, el);
                check_op("rand_op", op, a, b, 2'b00, eh, el);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start   = 1'b0;
        bus.md_op   = 2'd0;
        bus.hilo_we = 2'b00;
        bus.A       = 32'd0;
        bus.B       = 32'd0;
        test_reset();
        test_plan_arith();
        test_hilo_write();
        test_div_zero();
        test_start_with_hilo();
        test_start_while_busy();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
